// File: rtl/fpu_mul_pipe_if.sv
// Operand/result bus of the pipelined floating-point multiplier.
// The master side (operand muxes / bench) drives operands, valid and stall;
// the slave side (the multiplier) returns the product and exception flags.
interface fpu_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int SIZE_DATA = 1 + EXP_W + MAN_W;

    logic                 i_stall;
    logic                 i_valid;
    logic [SIZE_DATA-1:0] i_a;
    logic [SIZE_DATA-1:0] i_b;
    logic                 o_valid;
    logic [SIZE_DATA-1:0] o_mul;
    logic                 o_invalid;
    logic                 o_overflow;
    logic                 o_underflow;

    modport master (
        output i_stall, i_valid, i_a, i_b,
        input  o_valid, o_mul, o_invalid, o_overflow, o_underflow
    );

    modport slave (
        input  i_stall, i_valid, i_a, i_b,
        output o_valid, o_mul, o_invalid, o_overflow, o_underflow
    );
endinterface

// File: rtl/fpu_mul_pipe.sv
// Three-stage pipelined IEEE-754-style multiplier (unpack / multiply /
// normalise-round-pack) with global stall, round-to-nearest-even,
// flush-to-zero of subnormal inputs and results, and exception flags.
module fpu_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fpu_mul_pipe_if.slave   bus
);
    localparam int SIZE_DATA = 1 + EXP_W + MAN_W;
    localparam int SIG_W     = MAN_W + 1;
    localparam int PROD_W    = 2 * SIG_W;
    localparam int SEXP_W    = EXP_W + 2;

    localparam logic [EXP_W-1:0]         EMAX   = '1;
    localparam logic signed [SEXP_W-1:0] BIAS_S = SEXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [SEXP_W-1:0] EMAX_S = SEXP_W'((1 << EXP_W) - 1);
    localparam logic signed [SEXP_W-1:0] ZERO_S = '0;
    localparam logic signed [SEXP_W-1:0] ONE_S  = SEXP_W'(1);
    localparam logic [SIZE_DATA-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // unpack fields
    logic                     sign_a, sign_b;
    logic [EXP_W-1:0]         exp_a, exp_b;
    logic [MAN_W-1:0]         frac_a, frac_b;
    logic                     zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                     cls_nan, cls_inf, cls_zero;
    logic signed [SEXP_W-1:0] exp_sum;

    // stage 1 registers
    logic                     s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [SEXP_W-1:0] s1_exp;
    logic [SIG_W-1:0]         s1_sig_a, s1_sig_b;

    // stage 2 registers
    logic                     s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [SEXP_W-1:0] s2_exp;
    logic [PROD_W-1:0]        s2_prod;

    // stage 3 combinational results
    logic                     hi;
    logic signed [SEXP_W-1:0] norm_exp, exp_final;
    logic [MAN_W-1:0]         man, man_final;
    logic                     guard, sticky, round_up;
    logic [MAN_W:0]           man_rnd;
    logic [SIZE_DATA-1:0]     result;
    logic                     f_inv, f_ovf, f_unf;

    // Classify operands; subnormals (exp=0) are treated as zero.
    always_comb begin
        sign_a   = bus.i_a[SIZE_DATA-1];
        sign_b   = bus.i_b[SIZE_DATA-1];
        exp_a    = bus.i_a[SIZE_DATA-2 -: EXP_W];
        exp_b    = bus.i_b[SIZE_DATA-2 -: EXP_W];
        frac_a   = bus.i_a[MAN_W-1:0];
        frac_b   = bus.i_b[MAN_W-1:0];
        zero_a   = (exp_a == '0);
        zero_b   = (exp_b == '0);
        inf_a    = (exp_a == EMAX) && (frac_a == '0);
        inf_b    = (exp_b == EMAX) && (frac_b == '0);
        nan_a    = (exp_a == EMAX) && (frac_a != '0);
        nan_b    = (exp_b == EMAX) && (frac_b != '0);
        cls_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
        cls_inf  = inf_a | inf_b;
        cls_zero = zero_a | zero_b;
        exp_sum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    end

    // Stage 1: register sign, biased exponent sum, significands and class.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_sig_a <= '0;
            s1_sig_b <= '0;
        end else if (!bus.i_stall) begin
            s1_valid <= bus.i_valid;
            s1_sign  <= sign_a ^ sign_b;
            s1_nan   <= cls_nan;
            s1_inf   <= cls_inf;
            s1_zero  <= cls_zero;
            s1_exp   <= exp_sum;
            s1_sig_a <= {1'b1, frac_a};
            s1_sig_b <= {1'b1, frac_b};
        end
    end

    // Stage 2: full-width significand product, class and exponent carried along.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
        end else if (!bus.i_stall) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_exp   <= s1_exp;
            s2_prod  <= PROD_W'(s1_sig_a) * PROD_W'(s1_sig_b);
        end
    end

    // Normalise the product, round to nearest even, then pick the final result.
    always_comb begin
        hi = s2_prod[PROD_W-1];
        if (hi) begin
            norm_exp = s2_exp + ONE_S;
            man      = s2_prod[PROD_W-2 -: MAN_W];
            guard    = s2_prod[MAN_W];
            sticky   = |s2_prod[MAN_W-1:0];
        end else begin
            norm_exp = s2_exp;
            man      = s2_prod[PROD_W-3 -: MAN_W];
            guard    = s2_prod[MAN_W-1];
            sticky   = |s2_prod[MAN_W-2:0];
        end
        round_up = guard & (sticky | man[0]);
        man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        if (man_rnd[MAN_W]) begin
            man_final = '0;
            exp_final = norm_exp + ONE_S;
        end else begin
            man_final = man_rnd[MAN_W-1:0];
            exp_final = norm_exp;
        end

        result = {s2_sign, exp_final[EXP_W-1:0], man_final};
        f_inv  = 1'b0;
        f_ovf  = 1'b0;
        f_unf  = 1'b0;
        if (s2_nan) begin
            result = QNAN;
            f_inv  = 1'b1;
        end else if (s2_inf) begin
            result = {s2_sign, EMAX, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            result = {s2_sign, {(SIZE_DATA-1){1'b0}}};
        end else if (exp_final >= EMAX_S) begin
            result = {s2_sign, EMAX, {MAN_W{1'b0}}};
            f_ovf  = 1'b1;
        end else if (exp_final <= ZERO_S) begin
            result = {s2_sign, {(SIZE_DATA-1){1'b0}}};
            f_unf  = 1'b1;
        end
    end

    // Stage 3: output register; flags are gated so bubbles never carry flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid     <= 1'b0;
            bus.o_mul       <= '0;
            bus.o_invalid   <= 1'b0;
            bus.o_overflow  <= 1'b0;
            bus.o_underflow <= 1'b0;
        end else if (!bus.i_stall) begin
            bus.o_valid     <= s2_valid;
            bus.o_mul       <= result;
            bus.o_invalid   <= f_inv & s2_valid;
            bus.o_overflow  <= f_ovf & s2_valid;
            bus.o_underflow <= f_unf & s2_valid;
        end
    end
endmodule
